// File: rtl/sram_rd_pkg.sv
// sram_rd_pkg: shared defaults and FSM state encoding for the SRAM read
// sequencer (sram_read_sequencer) and its output FIFO (sram_rd_fifo).
package sram_rd_pkg;

  localparam int unsigned DEF_NUM_BANKS  = 10;
  localparam int unsigned DEF_DATA_W     = 16;
  localparam int unsigned DEF_ADDR_W     = 16;
  localparam int unsigned DEF_FIFO_DEPTH = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FINISH = 2'd3
  } rd_state_e;

endpackage

// File: rtl/sram_rd_fifo.sv
// sram_rd_fifo: parameterised synchronous FIFO, asynchronous active-high reset.
// Ports:
//   clk, rst      clock, async active-high reset (clears storage and pointers)
//   push, din     write request and data (ignored when full unless popping)
//   pop, dout     read request and head data (dout = din while empty)
//   count         number of stored entries
//   empty, full   occupancy flags
// Push and pop together when empty hand din straight through; count unchanged.
module sram_rd_fifo #(
  parameter int unsigned WIDTH = 161,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full
);

  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_en, rd_en, bypass;

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    empty  = (cnt_q == '0);
    full   = (cnt_q == CNT_W'(DEPTH));
    bypass = empty & push & pop;
    wr_en  = push & ~bypass & (~full | pop);
    rd_en  = pop & ~empty;
    if (wr_en) begin
      mem_d[wr_q] = din;
      wr_d = (wr_q == LAST_PTR) ? '0 : wr_q + PTR_W'(1);
    end
    if (rd_en) begin
      rd_d = (rd_q == LAST_PTR) ? '0 : rd_q + PTR_W'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    dout  = empty ? din : mem_q[rd_q];
    count = cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      mem_q <= mem_d;
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sram_read_sequencer.sv
// sram_read_sequencer: streams len beats from a bank array sharing one address,
// starting at base_addr, through a small FIFO onto a valid/ready lane port.
// Ports:
//   clk, reset               clock, async active-high reset
//   start, base_addr, len    request (sampled only in IDLE; len may be 0)
//   sram_addr, sram_write    shared bank address (wraps), write strobe (always 0)
//   sram_rdata               bank read data, one cycle after sram_addr
//   out_valid/ready/data     lane vector handshake; out_last marks final beat
//   busy, done               request in progress, one-cycle completion pulse
//   stall_cycles             only with SRAM_RD_PERF_EN: cycles out_valid & !out_ready
// Optional feature macro: SRAM_RD_PERF_EN.
module sram_read_sequencer
  import sram_rd_pkg::*;
#(
  parameter int unsigned NUM_BANKS  = DEF_NUM_BANKS,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned ADDR_W     = DEF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [ADDR_W-1:0]           len,
  output logic [ADDR_W-1:0]           sram_addr,
  output logic                        sram_write,
  input  logic [NUM_BANKS*DATA_W-1:0] sram_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_BANKS*DATA_W-1:0] out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic                        done
`ifdef SRAM_RD_PERF_EN
  ,
  output logic [31:0]                 stall_cycles
`endif
);

  localparam int unsigned LANE_W = NUM_BANKS * DATA_W;
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] left_q, left_d;
  logic              inflight_q, inflight_d;
  logic              inflight_last_q, inflight_last_d;

  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    occupancy;
  logic [LANE_W:0]   fifo_dout;
  logic              fifo_empty, fifo_full, fifo_push, fifo_pop;

  // Credit check uses registered terms only, so out_ready never reaches sram_addr.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    left_d          = left_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          addr_d  = base_addr;
          left_d  = len;
          state_d = (len == '0) ? FINISH : RUN;
        end
      end
      RUN: begin
        if (occupancy < (CNT_W + 1)'(FIFO_DEPTH)) begin
          addr_d          = addr_q + ADDR_W'(1);
          left_d          = left_q - ADDR_W'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (left_q == ADDR_W'(1));
          if (left_q == ADDR_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (fifo_pop && fifo_dout[LANE_W]) state_d = FINISH;
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      addr_q          <= '0;
      left_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      left_q          <= left_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // The credit check keeps room for every in-flight read; the full gate only
  // protects the storage and never blocks in normal operation.
  assign fifo_push = inflight_q & (~fifo_full | fifo_pop);
  assign fifo_pop  = out_valid & out_ready;

  sram_rd_fifo #(
    .WIDTH (LANE_W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (reset),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({inflight_last_q, sram_rdata}),
    .dout  (fifo_dout),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign sram_addr  = addr_q;
  assign sram_write = 1'b0;
  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? '0 : fifo_dout[LANE_W-1:0];
  assign out_last   = ~fifo_empty & fifo_dout[LANE_W];
  assign busy       = (state_q != IDLE);
  assign done       = (state_q == FINISH);

`ifdef SRAM_RD_PERF_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (state_q == IDLE && start) begin
      stall_d = '0;
    end else if (out_valid && !out_ready && stall_q != '1) begin
      stall_d = stall_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_sram_read_sequencer.sv
module tb_sram_read_sequencer;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [15:0]  base_addr;
  logic [15:0]  len;
  logic [15:0]  sram_addr;
  logic         sram_write;
  logic [159:0] sram_rdata;
  logic         out_valid;
  logic         out_ready;
  logic [159:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;
`ifdef SRAM_RD_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  int           tests = 0;
  int           failed = 0;
  logic [160:0] sb[$];
  logic [15:0]  salt = 16'h0000;

  always #5 clk = ~clk;

  sram_read_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base_addr  (base_addr),
    .len        (len),
    .sram_addr  (sram_addr),
    .sram_write (sram_write),
    .sram_rdata (sram_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
`ifdef SRAM_RD_PERF_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  function automatic logic [159:0] lanes(input logic [15:0] a, input logic [15:0] s);
    logic [159:0] v;
    for (int k = 0; k < 10; k++) v[k*16 +: 16] = 16'(k * 256) + a + s;
    return v;
  endfunction

  // Bank model: read data one cycle after the address.
  always @(posedge clk) sram_rdata <= lanes(sram_addr, salt);

  task automatic push_exp(input logic [15:0] b, input logic [15:0] n);
    for (int i = 0; i < int'(n); i++)
      sb.push_back({(i == int'(n) - 1), lanes(b + 16'(i), salt)});
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({sram_addr, sram_write, out_valid, out_data, out_last, busy, done} !== '0) begin
      failed++;
      $display("FAIL reset_values addr=%h wr=%b v=%b data=%h last=%b busy=%b done=%b expected all 0",
               sram_addr, sram_write, out_valid, out_data, out_last, busy, done);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int beats = 0, dones = 0;
    logic [160:0] e;
    salt = 16'h0000; sb.delete(); push_exp(16'h0000, 16'd4);
    out_ready = 1'b1; base_addr = 16'h0000; len = 16'd4; start = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (cyc == 1) begin
        tests++;
        if (sram_addr !== 16'h0000 || busy !== 1'b1) begin
          failed++;
          $display("FAIL basic_first_addr addr=%h busy=%b expected 0000 1", sram_addr, busy);
        end
      end
      if (cyc == 2) begin
        tests++;
        if (out_valid !== 1'b0) begin
          failed++; $display("FAIL basic_early_valid valid=%b expected 0 at cycle 2", out_valid);
        end
      end
      if (out_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          failed++; $display("FAIL basic_extra_beat data=%h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_last, out_data} !== e || cyc != 3 + beats) begin
            failed++;
            $display("FAIL basic_beat%0d cyc=%0d last=%b data=%h expected cyc=%0d last=%b data=%h",
                     beats, cyc, out_last, out_data, 3 + beats, e[160], e[159:0]);
          end
        end
        beats++;
      end
      if (done === 1'b1) begin
        dones++; tests++;
        if (cyc != 7) begin
          failed++; $display("FAIL basic_done_cycle cyc=%0d expected 7", cyc);
        end
      end
    end
    tests++;
    if (beats != 4 || dones != 1 || busy !== 1'b0) begin
      failed++;
      $display("FAIL basic_totals beats=%0d dones=%0d busy=%b expected 4 1 0", beats, dones, busy);
    end
  endtask

  task automatic test_toggle_ready();
    int beats = 0;
    logic [160:0] e;
    salt = 16'h1000; sb.delete(); push_exp(16'h0100, 16'd8);
    base_addr = 16'h0100; len = 16'd8; start = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk); start = 1'b0; out_ready = (cyc % 2 == 1);
      if (out_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          failed++; $display("FAIL toggle_extra_beat data=%h expected no beat", out_data);
        end else if (out_ready) begin
          e = sb.pop_front();
          if ({out_last, out_data} !== e) begin
            failed++;
            $display("FAIL toggle_beat%0d last=%b data=%h expected last=%b data=%h",
                     beats, out_last, out_data, e[160], e[159:0]);
          end
          beats++;
        end else if ({out_last, out_data} !== sb[0]) begin
          failed++;
          $display("FAIL toggle_stalled_hold last=%b data=%h expected last=%b data=%h",
                   out_last, out_data, sb[0][160], sb[0][159:0]);
        end
      end
    end
    tests++;
    if (beats != 8 || busy !== 1'b0) begin
      failed++; $display("FAIL toggle_totals beats=%0d busy=%b expected 8 0", beats, busy);
    end
  endtask

  task automatic test_stall();
    int beats = 0;
    logic [160:0] e;
    salt = 16'h2000; sb.delete(); push_exp(16'h0020, 16'd6);
    base_addr = 16'h0020; len = 16'd6; start = 1'b1; out_ready = 1'b0;
    for (int cyc = 1; cyc <= 30; cyc++) begin
      @(negedge clk); start = 1'b0; out_ready = (cyc > 10);
      if (cyc == 5 || cyc == 10) begin
        tests++;
        if (sram_addr !== 16'h0023 || out_valid !== 1'b1) begin
          failed++;
          $display("FAIL stall_three_reads cyc=%0d addr=%h valid=%b expected 0023 1",
                   cyc, sram_addr, out_valid);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        tests++;
        if (sb.size() == 0) begin
          failed++; $display("FAIL stall_extra_beat data=%h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_last, out_data} !== e) begin
            failed++;
            $display("FAIL stall_beat%0d last=%b data=%h expected last=%b data=%h",
                     beats, out_last, out_data, e[160], e[159:0]);
          end
        end
        beats++;
      end
    end
    tests++;
    if (beats != 6) begin
      failed++; $display("FAIL stall_totals beats=%0d expected 6", beats);
    end
  endtask

  task automatic test_wrap();
    int beats = 0;
    logic [160:0] e;
    logic [15:0] ea;
    salt = 16'h3000; sb.delete(); push_exp(16'hFFFE, 16'd4);
    base_addr = 16'hFFFE; len = 16'd4; start = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 14; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (cyc <= 4) begin
        ea = 16'hFFFE + 16'(cyc - 1);
        tests++;
        if (sram_addr !== ea) begin
          failed++; $display("FAIL wrap_addr cyc=%0d addr=%h expected %h", cyc, sram_addr, ea);
        end
      end
      if (out_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          failed++; $display("FAIL wrap_extra_beat data=%h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_last, out_data} !== e) begin
            failed++;
            $display("FAIL wrap_beat%0d last=%b data=%h expected last=%b data=%h",
                     beats, out_last, out_data, e[160], e[159:0]);
          end
        end
        beats++;
      end
    end
    tests++;
    if (beats != 4) begin
      failed++; $display("FAIL wrap_totals beats=%0d expected 4", beats);
    end
  endtask

  task automatic test_len_zero();
    int dones = 0, valids = 0;
    base_addr = 16'h0077; len = 16'd0; start = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (out_valid !== 1'b0) valids++;
      if (done === 1'b1) begin
        dones++; tests++;
        if (cyc != 1 || busy !== 1'b1) begin
          failed++; $display("FAIL len0_done cyc=%0d busy=%b expected cyc=1 busy=1", cyc, busy);
        end
      end
    end
    tests++;
    if (dones != 1 || valids != 0 || busy !== 1'b0) begin
      failed++;
      $display("FAIL len0_totals dones=%0d valid_cycles=%0d busy=%b expected 1 0 0",
               dones, valids, busy);
    end
  endtask

  task automatic test_reset_mid();
    int beats = 0;
    bit hit = 0;
    logic [160:0] e;
    salt = 16'h4000; sb.delete(); push_exp(16'h0040, 16'd8);
    base_addr = 16'h0040; len = 16'd8; start = 1'b1; out_ready = 1'b1;
    for (int cyc = 1; cyc <= 20 && !hit; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (out_valid === 1'b1 && beats == 2) begin
        hit = 1;
        reset = 1'b1;
        #1;
        tests++;
        if ({sram_addr, sram_write, out_valid, out_data, out_last, busy, done} !== '0) begin
          failed++;
          $display("FAIL midreset_values addr=%h v=%b data=%h last=%b busy=%b done=%b expected all 0",
                   sram_addr, out_valid, out_data, out_last, busy, done);
        end
      end else if (out_valid === 1'b1) begin
        e = sb.pop_front();
        beats++;
      end
    end
    tests++;
    if (!hit) begin
      failed++; $display("FAIL midreset_timeout beats=%0d expected beat 2 within budget", beats);
    end
    @(negedge clk); reset = 1'b0;
    beats = 0;
    salt = 16'h5000; sb.delete(); push_exp(16'h0050, 16'd2);
    base_addr = 16'h0050; len = 16'd2; start = 1'b1;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk); start = 1'b0;
      if (out_valid === 1'b1) begin
        tests++;
        if (sb.size() == 0) begin
          failed++; $display("FAIL midreset_extra_beat data=%h expected no beat", out_data);
        end else begin
          e = sb.pop_front();
          if ({out_last, out_data} !== e) begin
            failed++;
            $display("FAIL midreset_new_beat%0d last=%b data=%h expected last=%b data=%h",
                     beats, out_last, out_data, e[160], e[159:0]);
          end
        end
        beats++;
      end
    end
    tests++;
    if (beats != 2) begin
      failed++; $display("FAIL midreset_totals beats=%0d expected 2", beats);
    end
  endtask

`ifdef SRAM_RD_PERF_EN
  task automatic test_perf();
    salt = 16'h0000; sb.delete();
    base_addr = 16'h0060; len = 16'd2; start = 1'b1; out_ready = 1'b0;
    for (int cyc = 1; cyc <= 15; cyc++) begin
      @(negedge clk); start = 1'b0; out_ready = (cyc > 7);
    end
    tests++;
    if (stall_cycles !== 32'd5) begin
      failed++; $display("FAIL perf_count stall=%0d expected 5", stall_cycles);
    end
    len = 16'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (stall_cycles !== 32'd0) begin
      failed++; $display("FAIL perf_clear stall=%0d expected 0", stall_cycles);
    end
    repeat (3) @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_toggle_ready();
    test_stall();
    test_wrap();
    test_len_zero();
    test_reset_mid();
`ifdef SRAM_RD_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
